// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed BCD 7-segment scan driver with blink and zero suppression
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic                  blink_en,
    output logic [6:0]            segs,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*DIGITS-1:0] shadow_digits;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   shadow_blank;

    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       index;
    logic [FW-1:0]       frame_cnt;
    logic                blink_phase;

    logic [DIGITS-1:0]   supp;
    logic                zero_run;
    logic [3:0]          cur_digit;
    logic                cur_dp;
    logic                cur_blank;
    logic                cur_supp;
    logic                visible;
    logic [DIGITS-1:0]   an_next;

    // Active-low abcdefg pattern; codes above 9 light nothing.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Shadow registers: the display only ever looks at these captured values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_digits <= {DIGITS{4'hF}};
            shadow_dp     <= '0;
            shadow_blank  <= '1;
        end else if (load) begin
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
            shadow_blank  <= blank_in;
        end
    end

    // Slot, digit, frame and blink-phase counters, all free-running.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            index       <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (index == IW'(DIGITS - 1)) begin
                index <= '0;
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end else begin
                index <= index + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Leading-zero run from the top digit down; forced blanks still count by value.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow_digits[4*i +: 4] == 4'h0);
            if (i > 0) begin
                supp[i] = lz_en && zero_run;
            end
        end
    end

    // Select the attributes of the digit currently being scanned.
    always_comb begin
        cur_digit = 4'hF;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_supp  = 1'b0;
        an_next   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IW'(i)) begin
                cur_digit = shadow_digits[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = shadow_blank[i];
                cur_supp  = supp[i];
                an_next[i] = 1'b0;
            end
        end
        visible = (scan_cnt != '0) && !(blink_en && blink_phase) && !cur_blank && !cur_supp;
    end

    // Registered drive of the shared segment bus and anodes; slot cycle 0 stays dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            segs <= 7'b1111111;
            dp   <= 1'b1;
            an   <= '1;
        end else if (visible) begin
            segs <= decode(cur_digit);
            dp   <= ~cur_dp;
            an   <= an_next;
        end else begin
            segs <= 7'b1111111;
            dp   <= 1'b1;
            an   <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic        blink_en = 1'b0;
    logic [6:0]  segs;
    logic        dp;
    logic [3:0]  an;

    int k;
    int n_checks;
    int n_fail;

    logic [6:0] tseg [D];
    logic       tlit [D];
    logic       tdp  [D];

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .lz_en(lz_en), .blink_en(blink_en),
        .segs(segs), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    // k is the state index (cycles since reset release) the current outputs reflect
    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ean,
                              input logic [6:0] eseg, input logic edp);
        n_checks++;
        assert ({an, segs, dp} === {ean, eseg, edp}) else begin
            n_fail++;
            $error("FAIL %s k=%0d: observed an=%b segs=%b dp=%b, expected an=%b segs=%b dp=%b",
                   tag, k, an, segs, dp, ean, eseg, edp);
        end
    endtask

    task automatic set_slot(input int i, input logic l, input logic [6:0] s, input logic d);
        tlit[i] = l;
        tseg[i] = s;
        tdp[i]  = d;
    endtask

    task automatic all_dark();
        for (int i = 0; i < D; i++) set_slot(i, 1'b0, 7'b1111111, 1'b0);
    endtask

    task automatic run_check(input string tag, input int n);
        int scan, idx, phase;
        logic [3:0] onehot;
        for (int c = 0; c < n; c++) begin
            tick();
            scan  = k % SD;
            idx   = (k / SD) % D;
            phase = (k / (SD * D * BF)) % 2;
            onehot = 4'b0001 << idx;
            if (scan != 0 && !(blink_en && phase == 1) && tlit[idx])
                expect_out(tag, ~onehot, tseg[idx], ~tdp[idx]);
            else
                expect_out(tag, 4'b1111, 7'b1111111, 1'b1);
        end
    endtask

    task automatic load_shadow(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits_in = d;
        dp_in     = p;
        blank_in  = b;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        k = 0;
        n_checks = 0;
        n_fail = 0;
        @(negedge clk);

        // 1: reset values while held, then shadow blank keeps the display dark
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_out("reset_hold", 4'b1111, 7'b1111111, 1'b1);
        end
        reset = 1'b0;
        k = -1;
        all_dark();
        run_check("no_load_dark", 40);

        // 2: 1234 with decimal point on digit 1
        load_shadow(16'h1234, 4'b0010, 4'b0000);
        set_slot(0, 1'b1, 7'b1001100, 1'b0);
        set_slot(1, 1'b1, 7'b0000110, 1'b1);
        set_slot(2, 1'b1, 7'b0010010, 1'b0);
        set_slot(3, 1'b1, 7'b1001111, 1'b0);
        run_check("scan_1234", 32);

        // 3: leading-zero suppression on 0070, then disabled
        lz_en = 1'b1;
        load_shadow(16'h0070, 4'b0000, 4'b0000);
        set_slot(0, 1'b1, 7'b0000001, 1'b0);
        set_slot(1, 1'b1, 7'b0001111, 1'b0);
        set_slot(2, 1'b0, 7'b1111111, 1'b0);
        set_slot(3, 1'b0, 7'b1111111, 1'b0);
        run_check("lz_on_0070", 32);
        lz_en = 1'b0;
        set_slot(2, 1'b1, 7'b0000001, 1'b0);
        set_slot(3, 1'b1, 7'b0000001, 1'b0);
        run_check("lz_off_0070", 32);

        // blanked non-zero digit stops the zero run; suppressed digit hides its dp
        lz_en = 1'b1;
        load_shadow(16'h0500, 4'b1000, 4'b0100);
        set_slot(0, 1'b1, 7'b0000001, 1'b0);
        set_slot(1, 1'b1, 7'b0000001, 1'b0);
        set_slot(2, 1'b0, 7'b1111111, 1'b0);
        set_slot(3, 1'b0, 7'b1111111, 1'b1);
        run_check("lz_blank_run", 32);
        lz_en = 1'b0;

        // 4: blink over 8888, two full blink half-periods
        blink_en = 1'b1;
        load_shadow(16'h8888, 4'b0000, 4'b0000);
        for (int i = 0; i < D; i++) set_slot(i, 1'b1, 7'b0000000, 1'b0);
        run_check("blink_8888", 96);
        blink_en = 1'b0;

        // 5: non-BCD codes keep the anode but light no segments
        load_shadow(16'hA9F5, 4'b0000, 4'b0000);
        set_slot(0, 1'b1, 7'b0100100, 1'b0);
        set_slot(1, 1'b1, 7'b1111111, 1'b0);
        set_slot(2, 1'b1, 7'b0000100, 1'b0);
        set_slot(3, 1'b1, 7'b1111111, 1'b0);
        run_check("hex_A9F5", 32);

        // 6: reset with load during slot 2
        for (int c = 0; c < 64 && (k % 16) != 9; c++) tick();
        expect_out("slot2_before_reset", 4'b1011, 7'b0000100, 1'b1);
        reset     = 1'b1;
        load      = 1'b1;
        digits_in = 16'h5678;
        blank_in  = 4'b0000;
        tick();
        expect_out("reset_with_load", 4'b1111, 7'b1111111, 1'b1);
        reset = 1'b0;
        load  = 1'b0;
        k = -1;
        all_dark();
        run_check("post_reset_blank", 16);
        load_shadow(16'h4321, 4'b0000, 4'b0000);
        set_slot(0, 1'b1, 7'b1001111, 1'b0);
        set_slot(1, 1'b1, 7'b0010010, 1'b0);
        set_slot(2, 1'b1, 7'b0000110, 1'b0);
        set_slot(3, 1'b1, 7'b1001100, 1'b0);
        run_check("reload_4321", 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
